// File: rtl/calc_pkg.sv
// Shared calculator display definitions: 7-segment decoder codes, range
// limits, and the converter FSM state encoding.
package calc_pkg;

  localparam int NUM_DIGITS         = 6;
  localparam int BCD_W              = 4 * NUM_DIGITS;
  localparam int unsigned MAX_MAG_DEFAULT    = 999999;
  localparam int unsigned SHIFT_BITS_DEFAULT = 20;
  // A minus sign consumes one digit position, so negatives have one digit less.
  localparam int unsigned NEG_MAX_MAG        = 99999;

  typedef logic [5:0] code_t;

  localparam code_t CODE_BLANK = 6'd36;
  localparam code_t CODE_MINUS = 6'd37;
  localparam code_t CODE_E     = 6'd14;
  localparam code_t CODE_R     = 6'd38;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_e;

  // Decimal digits 0-9 map directly onto decoder codes 0-9.
  function automatic code_t bcd_to_code(input logic [3:0] nib);
    return {2'b00, nib};
  endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD decade: a nibble of 5 or more gets 3
// added so the following left shift carries cleanly into the next decade.
module bcd_add3_nibble (
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= 4'd5) ? i_nibble + 4'd3 : i_nibble;

endmodule

// File: rtl/bcd_digit_converter.sv
// Converts a calculator result (magnitude, sign, error flag) into six
// 7-segment decoder codes using a serial double-dabble, with leading-zero
// suppression, a minus sign and an E,R,R pattern for errors and overflow.
module bcd_digit_converter
  import calc_pkg::*;
#(
  parameter int unsigned MAX_MAG    = MAX_MAG_DEFAULT,
  parameter int unsigned SHIFT_BITS = SHIFT_BITS_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [39:0] i_value,
  input  logic        i_sign,
  input  logic        i_err,
  output logic [5:0]  o_digit0,
  output logic [5:0]  o_digit1,
  output logic [5:0]  o_digit2,
  output logic [5:0]  o_digit3,
  output logic [5:0]  o_digit4,
  output logic [5:0]  o_digit5,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow
);

  localparam int CNT_W = $clog2(SHIFT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_BITS - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [SHIFT_BITS-1:0] bin_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [BCD_W-1:0]      bcd_adj;
  logic                  sign_q;
  logic                  err_q;
  logic                  ovf_q;

  code_t digit_q [NUM_DIGITS];
  code_t fmt_digits [NUM_DIGITS];
  logic  done_q;
  logic  overflow_q;

  logic busy;
  logic load_en;
  logic shift_en;
  logic fmt_en;
  logic range_bad;
  int   msd;

  // Out of range: too large overall, or too large to leave room for a minus.
  assign range_bad = (i_value > 40'(MAX_MAG)) ||
                     (i_sign && (i_value > 40'(NEG_MAX_MAG)));

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .i_nibble (bcd_q[4*g +: 4]),
      .o_nibble (bcd_adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: error cases skip the shift phase entirely.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_start) state_d = (i_err || range_bad) ? ST_FORMAT : ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CNT_LAST) state_d = ST_FORMAT;
      ST_FORMAT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: phase enables and the busy flag follow the current state.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    load_en  = (state_q == ST_IDLE) && i_start;
    shift_en = (state_q == ST_SHIFT);
    fmt_en   = (state_q == ST_FORMAT);
  end

  // Capture the request, then run one add-3/shift iteration per clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load_en) begin
      cnt_q  <= '0;
      bin_q  <= i_value[SHIFT_BITS-1:0];
      bcd_q  <= '0;
      sign_q <= i_sign;
      err_q  <= i_err;
      ovf_q  <= !i_err && range_bad;
    end else if (shift_en) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      cnt_q          <= cnt_q + CNT_W'(1);
    end
  end

  // Display formatting: blank leading zeros, place a minus, or show E,R,R.
  always_comb begin
    fmt_digits = '{default: CODE_BLANK};
    msd        = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    if (err_q || ovf_q) begin
      fmt_digits[2] = CODE_E;
      fmt_digits[1] = CODE_R;
      fmt_digits[0] = CODE_R;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (i <= msd) begin
          fmt_digits[i] = bcd_to_code(bcd_q[4*i +: 4]);
        end else if (sign_q && (bcd_q != '0) && (i == msd + 1)) begin
          fmt_digits[i] = CODE_MINUS;
        end
      end
    end
  end

  // Result registers: updated together with the done pulse, held otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      digit_q    <= '{default: CODE_BLANK};
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= fmt_en;
      if (fmt_en) begin
        digit_q    <= fmt_digits;
        overflow_q <= ovf_q;
      end
    end
  end

  assign o_digit0   = digit_q[0];
  assign o_digit1   = digit_q[1];
  assign o_digit2   = digit_q[2];
  assign o_digit3   = digit_q[3];
  assign o_digit4   = digit_q[4];
  assign o_digit5   = digit_q[5];
  assign o_busy     = busy;
  assign o_done     = done_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Self-checking bench for bcd_digit_converter: directed corner cases plus
// randomized conversions checked against an arithmetic reference model.
module tb_bcd_digit_converter;

  localparam logic [5:0] C_BLANK = 6'd36;
  localparam logic [5:0] C_MINUS = 6'd37;
  localparam logic [5:0] C_E     = 6'd14;
  localparam logic [5:0] C_R     = 6'd38;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [39:0] i_value;
  logic        i_sign;
  logic        i_err;
  logic [5:0]  o_digit0, o_digit1, o_digit2, o_digit3, o_digit4, o_digit5;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;

  int errors = 0;
  int checks = 0;

  bcd_digit_converter dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_value    (i_value),
    .i_sign     (i_sign),
    .i_err      (i_err),
    .o_digit0   (o_digit0),
    .o_digit1   (o_digit1),
    .o_digit2   (o_digit2),
    .o_digit3   (o_digit3),
    .o_digit4   (o_digit4),
    .o_digit5   (o_digit5),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [35:0] shown();
    return {o_digit5, o_digit4, o_digit3, o_digit2, o_digit1, o_digit0};
  endfunction

  // Expected display from decimal arithmetic. Latency counts clock edges
  // inclusively: the start edge is edge 1, the edge raising o_done is edge lat.
  function automatic void ref_model(input logic [39:0] v, input logic s, input logic e,
                                    output logic [35:0] dig, output logic ovf, output int lat);
    longint unsigned mag, tmp, p;
    int ndig;
    logic [5:0] d;
    if (e || v > 40'd999999 || (s && v > 40'd99999)) begin
      dig = {C_BLANK, C_BLANK, C_BLANK, C_E, C_R, C_R};
      ovf = !e;
      lat = 2;
      return;
    end
    mag  = 64'(v);
    tmp  = mag;
    ndig = 0;
    do begin
      ndig++;
      tmp = tmp / 10;
    end while (tmp != 0);
    p = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < ndig)                         d = 6'((mag / p) % 10);
      else if (s && mag != 0 && i == ndig)  d = C_MINUS;
      else                                  d = C_BLANK;
      dig[6*i +: 6] = d;
      p = p * 10;
    end
    ovf = 1'b0;
    lat = 22;
  endfunction

  // One conversion: start, scramble inputs while busy, measure latency and
  // compare the result. poke re-asserts i_start during busy with other data.
  task automatic convert(input logic [39:0] v, input logic s, input logic e,
                         input bit poke, input bit hold_check, input string tag);
    logic [35:0] exp_dig;
    logic        exp_ovf;
    int          exp_lat;
    int          edges;
    int          extra_done;
    bit          seen;
    int unsigned ra, rb;
    ref_model(v, s, e, exp_dig, exp_ovf, exp_lat);
    @(negedge i_clk);
    i_value = v;
    i_sign  = s;
    i_err   = e;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_at_start: got %b want 1", tag, o_busy);
    end
    edges = 1;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(negedge i_clk);
      ra      = $urandom;
      rb      = $urandom;
      i_value = {ra[7:0], rb};
      i_sign  = 1'($urandom);
      i_err   = 1'($urandom);
      i_start = poke && (edges == 1);
      @(posedge i_clk);
      edges++;
      #1;
      if (o_done === 1'b1) seen = 1'b1;
    end
    i_start = 1'b0;
    checks++;
    if (!seen || edges != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (done seen=%0d) want %0d", tag, edges, seen, exp_lat);
    end
    checks++;
    if (shown() !== exp_dig) begin
      errors++;
      $display("FAIL %s digits: got %h want %h", tag, shown(), exp_dig);
    end
    checks++;
    if (o_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s overflow: got %b want %b", tag, o_overflow, exp_ovf);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 0", tag, o_busy);
    end
    if (hold_check) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_done !== 1'b0 || shown() !== exp_dig) begin
        errors++;
        $display("FAIL %s hold: done=%b digits=%h want done=0 digits=%h", tag, o_done, shown(), exp_dig);
      end
    end
    if (poke) begin
      extra_done = 0;
      repeat (25) begin
        @(posedge i_clk);
        #1;
        if (o_done === 1'b1 || o_busy === 1'b1) extra_done++;
      end
      checks++;
      if (extra_done != 0) begin
        errors++;
        $display("FAIL %s ignored_start: got %0d busy/done cycles want 0", tag, extra_done);
      end
    end
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_value = '0;
    i_sign  = 1'b0;
    i_err   = 1'b0;
    #12;
    checks++;
    if (shown() !== {6{C_BLANK}} || o_busy !== 1'b0 || o_done !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h busy=%b done=%b ovf=%b want all blank/0",
               shown(), o_busy, o_done, o_overflow);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_directed();
    convert(40'd123456,  1'b0, 1'b0, 1'b0, 1'b1, "dir_123456");
    convert(40'd42,      1'b1, 1'b0, 1'b0, 1'b1, "dir_neg42");
    convert(40'd0,       1'b1, 1'b0, 1'b0, 1'b1, "dir_neg_zero");
    convert(40'd0,       1'b0, 1'b0, 1'b0, 1'b1, "dir_zero");
    convert(40'd1000000, 1'b0, 1'b0, 1'b0, 1'b1, "dir_ovf_pos");
    convert(40'd100000,  1'b1, 1'b0, 1'b0, 1'b1, "dir_ovf_neg");
    convert(40'd999999,  1'b0, 1'b0, 1'b0, 1'b1, "dir_max_pos");
    convert(40'd99999,   1'b1, 1'b0, 1'b0, 1'b1, "dir_max_neg");
    convert(40'd100000,  1'b0, 1'b0, 1'b0, 1'b1, "dir_100000");
    convert(40'd10,      1'b1, 1'b0, 1'b0, 1'b1, "dir_neg10");
    convert(40'd7,       1'b0, 1'b1, 1'b0, 1'b1, "dir_err");
  endtask

  task automatic test_busy_ignore();
    convert(40'd7,   1'b0, 1'b1, 1'b1, 1'b0, "busy_err_poke");
    convert(40'd321, 1'b0, 1'b0, 1'b1, 1'b0, "busy_norm_poke");
  endtask

  task automatic test_reset_mid_shift();
    convert(40'd1000000, 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset_ovf");
    @(negedge i_clk);
    i_value = 40'd555555;
    i_sign  = 1'b0;
    i_err   = 1'b0;
    i_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (shown() !== {6{C_BLANK}} || o_busy !== 1'b0 || o_done !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_reset: digits=%h busy=%b done=%b ovf=%b want all blank/0",
               shown(), o_busy, o_done, o_overflow);
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (25) begin
      @(posedge i_clk);
      #1;
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: done=%b busy=%b want 0 0", o_done, o_busy);
      end
    end
    convert(40'd999999, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset_999999");
  endtask

  task automatic test_back_to_back();
    convert(40'd314159, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_0");
    convert(40'd2718,   1'b1, 1'b0, 1'b0, 1'b0, "b2b_1");
    convert(40'd5,      1'b0, 1'b1, 1'b0, 1'b0, "b2b_2");
    convert(40'd4000000,1'b0, 1'b0, 1'b0, 1'b1, "b2b_3");
  endtask

  task automatic test_random();
    logic [39:0] v;
    logic        s, e;
    int unsigned ra, rb;
    for (int n = 0; n < 40; n++) begin
      e = 1'b0;
      s = 1'($urandom);
      case ($urandom_range(0, 4))
        0: v = 40'($urandom_range(0, 999999));
        1: begin v = 40'($urandom_range(0, 99999)); s = 1'b1; end
        2: v = 40'($urandom_range(0, 99));
        3: begin
          ra = $urandom;
          rb = $urandom;
          v  = ($urandom_range(0, 1) == 0) ? 40'(1000000 + $urandom_range(0, 1000000))
                                           : {ra[7:0] | 8'h01, rb};
        end
        default: begin
          ra = $urandom;
          rb = $urandom;
          v  = {ra[7:0], rb};
          e  = 1'b1;
        end
      endcase
      convert(v, s, e, 1'b0, ($urandom_range(0, 1) == 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_digit_converter.md
BCD_DIGIT_CONVERTER -- requirements
Module: bcd_digit_converter

Interface
REQ-001 SHALL have parameter MAX_MAG, default 999999: largest displayable unsigned magnitude.
REQ-002 SHALL have parameter SHIFT_BITS, default 20: double-dabble iteration count; 2^SHIFT_BITS > MAX_MAG.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: request a conversion; sampled only in IDLE.
REQ-006 SHALL have port i_value, input, 40: unsigned magnitude of the calculator result.
REQ-007 SHALL have port i_sign, input, 1: 1 = negative result.
REQ-008 SHALL have port i_err, input, 1: 1 = calculator error.
REQ-009 SHALL have ports o_digit0..o_digit5, output, 6 each: 7-segment decoder codes, digit0 = units, digit5 = hundred-thousands.
REQ-010 SHALL have port o_busy, output, 1: high while a conversion is in progress.
REQ-011 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port o_overflow, output, 1: last conversion was out of range; held until the next completion.

Function
REQ-013 SHALL use display codes 0-9 = decimal digits, BLANK = 6'd36, MINUS = 6'd37, E = 6'd14, R = 6'd38.
REQ-014 SHALL implement FSM states IDLE, SHIFT, FORMAT.
REQ-015 SHALL, in IDLE with i_start=1, capture i_value, i_sign and i_err into internal registers and assert o_busy at that edge.
REQ-016 SHALL treat a conversion as an error case when i_err=1, i_value > MAX_MAG, or i_sign=1 with i_value > 99999.
REQ-017 SHALL, for an error case, go IDLE->FORMAT without entering SHIFT.
REQ-018 SHALL, for all other cases, go IDLE->SHIFT.
REQ-019 SHALL, in SHIFT, run exactly SHIFT_BITS double-dabble iterations, one per clock: add 3 to every BCD nibble >= 5, then shift left by 1, MSB of the magnitude entering nibble 0.
REQ-020 SHALL use an iteration counter to leave SHIFT for FORMAT after the last iteration.
REQ-021 SHALL, in FORMAT, update all digit outputs, o_overflow and o_done=1 on the same edge, clear o_busy, and return to IDLE.
REQ-022 SHALL set latency from the start edge to the edge that raises o_done to 22 clocks for the normal path and 2 clocks for the error path.
REQ-023 SHALL blank all zeros above the most significant nonzero digit (leading-zero suppression).
REQ-024 SHALL display magnitude 0 as digit0 = 0 with all other digits BLANK, and SHALL ignore sign for zero.
REQ-025 SHALL, for a negative result, place MINUS in the digit immediately left of the most significant digit.
REQ-026 SHALL, when i_err=1, display digit2..0 = E,R,R, digit5..3 = BLANK, and o_overflow=0.
REQ-027 SHALL, on range overflow, display the same E,R,R pattern with o_overflow=1.
REQ-028 SHALL ignore i_start while o_busy=1, and SHALL ignore input changes after capture.
REQ-029 SHALL hold the digit outputs stable between completions.
REQ-030 SHALL allow back-to-back conversions: a start in the cycle after o_done is accepted.

Reset
REQ-031 SHALL, on i_rst=1 at any time including mid-SHIFT, asynchronously force: state IDLE, counter 0, o_busy 0, o_done 0, o_overflow 0, all digits BLANK.
REQ-032 SHALL start no conversion until i_start is sampled after reset deasserts.

Structure
REQ-033 SHALL take display codes, MAX_MAG defaults and FSM state encoding from the shared package calc_pkg, reused by state_controller and the segment decoder.
REQ-034 SHALL use one sub-module, bcd_add3_nibble, for the per-nibble conditional add-3, instantiated 6 times.

Verification
REQ-035 SHALL verify: start, value=123456, sign=0 -> after 22 clocks o_done pulse, digits5..0 = 1,2,3,4,5,6, o_overflow=0.
REQ-036 SHALL verify: start, value=42, sign=1 -> digits = BLANK,BLANK,BLANK,MINUS,4,2.
REQ-037 SHALL verify: start, value=0, sign=1 -> digit0=0, others BLANK, no MINUS.
REQ-038 SHALL verify: start, value=1000000; and separately value=100000 with sign=1 -> o_done after 2 clocks, E,R,R pattern, o_overflow=1.
REQ-039 SHALL verify: start, value=7 with i_err=1 -> E,R,R, o_overflow=0; a second start during busy is ignored.
REQ-040 SHALL verify: i_rst asserted at SHIFT iteration 10 -> outputs BLANK immediately, no o_done; a new start after reset converts 999999 correctly.
